// File: rtl/uart_cmd_pkg.sv
// Shared ASCII constants, decoder state encoding and small helpers for the UART command decoder.
package uart_cmd_pkg;

    localparam logic [7:0] ASC_CR   = 8'h0D;
    localparam logic [7:0] ASC_LF   = 8'h0A;
    localparam logic [7:0] ASC_W    = 8'h57;
    localparam logic [7:0] ASC_R    = 8'h52;
    localparam logic [7:0] ASC_K    = 8'h4B;
    localparam logic [7:0] ASC_BANG = 8'h21;
    localparam logic [7:0] ASC_NL   = 8'h0A;

    localparam int REPLY_LEN = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_HI,
        ST_W_LO,
        ST_W_END,
        ST_R_END,
        ST_DISCARD,
        ST_ERR_REPLY,
        ST_REPLY
    } state_t;

    function automatic logic is_term(input logic [7:0] b);
        return (b == ASC_CR) || (b == ASC_LF);
    endfunction

    function automatic logic [7:0] nib_to_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Byte-level link between the UART rx/tx handshake and the command decoder, plus its LED/error outputs.
interface uart_cmd_decoder_if;
    logic       rx_valid_i;
    logic [7:0] rx_byte_i;
    logic       tx_busy_i;
    logic       tx_start_o;
    logic [7:0] tx_byte_o;
    logic [7:0] led_o;
    logic       err_o;

    modport master (
        output rx_valid_i, rx_byte_i, tx_busy_i,
        input  tx_start_o, tx_byte_o, led_o, err_o
    );

    modport slave (
        input  rx_valid_i, rx_byte_i, tx_busy_i,
        output tx_start_o, tx_byte_o, led_o, err_o
    );
endinterface

// File: rtl/hex_ascii_codec.sv
// Combinational ASCII hex digit <-> nibble conversion; encode side is always uppercase.
// UART_CMD_LOWERCASE_EN also decodes 'a'-'f'.
module hex_ascii_codec
    import uart_cmd_pkg::*;
(
    input  logic [7:0] asc,
    output logic [3:0] nib,
    output logic       nib_ok,
    input  logic [7:0] enc_byte,
    output logic [7:0] enc_hi,
    output logic [7:0] enc_lo
);
    always_comb begin
        nib    = 4'h0;
        nib_ok = 1'b0;
        if (asc >= 8'h30 && asc <= 8'h39) begin
            nib    = asc[3:0];
            nib_ok = 1'b1;
        end else if (asc >= 8'h41 && asc <= 8'h46) begin
            nib    = asc[3:0] + 4'd9;
            nib_ok = 1'b1;
        end
`ifdef UART_CMD_LOWERCASE_EN
        else if (asc >= 8'h61 && asc <= 8'h66) begin
            nib    = asc[3:0] + 4'd9;
            nib_ok = 1'b1;
        end
`endif
    end

    assign enc_hi = nib_to_ascii(enc_byte[7:4]);
    assign enc_lo = nib_to_ascii(enc_byte[3:0]);
endmodule

// File: rtl/uart_cmd_decoder.sv
// Line-oriented ASCII decoder: "Whh<T>" writes the LED register, "R<T>" reads it back; replies paced by tx_busy_i.
// UART_CMD_LOWERCASE_EN accepts lowercase command letters and hex digits; LED update lands one edge after the terminator.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 12_000_000,
    parameter logic [7:0]  LED_RESET      = 8'h00
) (
    input  logic              CLK_i,
    input  logic              RSTn_i,
    uart_cmd_decoder_if.slave bus
);
    localparam int unsigned     TO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state;
    logic [TO_W-1:0] to_cnt;
    logic [7:0]      reply_buf [REPLY_LEN];
    logic [1:0]      reply_len;
    logic [1:0]      reply_idx;
    logic            tx_gap;
    logic [7:0]      wr_val;
    logic [7:0]      led_q;
    logic            tx_start_q;
    logic [7:0]      tx_byte_q;
    logic            err_q;

    logic       rx_vld;
    logic [7:0] rx_dat;
    logic       rx_term;
    logic       rx_is_w;
    logic       rx_is_r;
    logic       rx_hex;
    logic [3:0] rx_nib;
    logic       counting;
    logic [7:0] led_hi_asc;
    logic [7:0] led_lo_asc;

    hex_ascii_codec u_codec (
        .asc      (rx_dat),
        .nib      (rx_nib),
        .nib_ok   (rx_hex),
        .enc_byte (led_q),
        .enc_hi   (led_hi_asc),
        .enc_lo   (led_lo_asc)
    );

    always_comb begin
        rx_vld   = bus.rx_valid_i;
        rx_dat   = bus.rx_byte_i;
        rx_term  = is_term(rx_dat);
        rx_is_w  = (rx_dat == ASC_W);
        rx_is_r  = (rx_dat == ASC_R);
`ifdef UART_CMD_LOWERCASE_EN
        rx_is_w  = rx_is_w | (rx_dat == (ASC_W | 8'h20));
        rx_is_r  = rx_is_r | (rx_dat == (ASC_R | 8'h20));
`endif
        counting = state inside {ST_W_HI, ST_W_LO, ST_W_END, ST_R_END, ST_DISCARD};
    end

    always_ff @(posedge CLK_i) begin
        if (!RSTn_i) begin
            state      <= ST_IDLE;
            to_cnt     <= '0;
            reply_len  <= 2'd0;
            reply_idx  <= 2'd0;
            tx_gap     <= 1'b0;
            wr_val     <= 8'h00;
            led_q      <= LED_RESET;
            tx_start_q <= 1'b0;
            tx_byte_q  <= 8'h00;
            err_q      <= 1'b0;
            for (int i = 0; i < REPLY_LEN; i++) reply_buf[i] <= 8'h00;
        end else begin
            tx_start_q <= 1'b0;
            err_q      <= 1'b0;

            // A byte landing on the expiry cycle wins: it clears the counter and is parsed below.
            if (!counting) begin
                to_cnt <= '0;
            end else if (rx_vld) begin
                to_cnt <= '0;
            end else if (to_cnt == TO_LAST) begin
                to_cnt <= '0;
                state  <= ST_IDLE;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end

            case (state)
                ST_IDLE: if (rx_vld) begin
                    if (rx_is_w)       state <= ST_W_HI;
                    else if (rx_is_r)  state <= ST_R_END;
                    else if (!rx_term) state <= ST_DISCARD;
                end
                ST_W_HI: if (rx_vld) begin
                    if (rx_term) begin
                        err_q <= 1'b1;
                        state <= ST_ERR_REPLY;
                    end else if (rx_hex) begin
                        wr_val[7:4] <= rx_nib;
                        state       <= ST_W_LO;
                    end else begin
                        state <= ST_DISCARD;
                    end
                end
                ST_W_LO: if (rx_vld) begin
                    if (rx_term) begin
                        err_q <= 1'b1;
                        state <= ST_ERR_REPLY;
                    end else if (rx_hex) begin
                        wr_val[3:0] <= rx_nib;
                        state       <= ST_W_END;
                    end else begin
                        state <= ST_DISCARD;
                    end
                end
                ST_W_END: if (rx_vld) begin
                    if (rx_term) begin
                        led_q        <= wr_val;
                        reply_buf[0] <= ASC_K;
                        reply_buf[1] <= ASC_NL;
                        reply_len    <= 2'd2;
                        reply_idx    <= 2'd0;
                        tx_gap       <= 1'b0;
                        state        <= ST_REPLY;
                    end else begin
                        state <= ST_DISCARD;
                    end
                end
                ST_R_END: if (rx_vld) begin
                    if (rx_term) begin
                        reply_buf[0] <= led_hi_asc;
                        reply_buf[1] <= led_lo_asc;
                        reply_buf[2] <= ASC_NL;
                        reply_len    <= 2'd3;
                        reply_idx    <= 2'd0;
                        tx_gap       <= 1'b0;
                        state        <= ST_REPLY;
                    end else begin
                        state <= ST_DISCARD;
                    end
                end
                ST_DISCARD: if (rx_vld && rx_term) begin
                    err_q <= 1'b1;
                    state <= ST_ERR_REPLY;
                end
                ST_ERR_REPLY: begin
                    if (rx_vld) err_q <= 1'b1;
                    reply_buf[0] <= ASC_BANG;
                    reply_buf[1] <= ASC_NL;
                    reply_len    <= 2'd2;
                    reply_idx    <= 2'd0;
                    tx_gap       <= 1'b0;
                    state        <= ST_REPLY;
                end
                ST_REPLY: begin
                    if (rx_vld) err_q <= 1'b1;
                    // Pulse cycle, then one dead cycle so the transmitter's busy has time to rise.
                    if (tx_start_q) begin
                        tx_gap <= 1'b1;
                    end else if (tx_gap) begin
                        tx_gap <= 1'b0;
                    end else if (reply_idx == reply_len) begin
                        state <= ST_IDLE;
                    end else if (!bus.tx_busy_i) begin
                        tx_start_q <= 1'b1;
                        tx_byte_q  <= reply_buf[reply_idx];
                        reply_idx  <= reply_idx + 2'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.tx_start_o = tx_start_q;
    assign bus.tx_byte_o  = tx_byte_q;
    assign bus.led_o      = led_q;
    assign bus.err_o      = err_q;
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Randomized and directed bench for uart_cmd_decoder against a line-level protocol model.
`timescale 1ns/1ps
module tb_uart_cmd_decoder;
    localparam int         TO      = 50;
    localparam logic [7:0] LED_RST = 8'h00;
    localparam logic [7:0] CR      = 8'h0D;
    localparam logic [7:0] LF      = 8'h0A;
`ifdef UART_CMD_LOWERCASE_EN
    localparam bit LC = 1'b1;
`else
    localparam bit LC = 1'b0;
`endif

    typedef logic [7:0] bq_t [$];

    logic clk = 1'b0;
    logic rst_n;
    uart_cmd_decoder_if bus ();

    uart_cmd_decoder #(.TIMEOUT_CYCLES(TO), .LED_RESET(LED_RST)) dut (
        .CLK_i  (clk),
        .RSTn_i (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         err_cnt = 0;
    int         busy_cnt = 0;
    bq_t        txq;
    logic [7:0] led_model = LED_RST;

    // Transmitter model: every tx_start_o seen is a transmitted byte, busy for 10 cycles afterwards.
    initial begin
        bus.tx_busy_i = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) bus.tx_busy_i = 1'b0;
            end
            if (bus.tx_start_o === 1'b1) begin
                txq.push_back(bus.tx_byte_o);
                bus.tx_busy_i = 1'b1;
                busy_cnt = 10;
            end
            if (bus.err_o === 1'b1) err_cnt++;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic bit is_hex(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
               (LC && c >= 8'h61 && c <= 8'h66);
    endfunction

    function automatic logic [3:0] hex_val(input logic [7:0] c);
        if (c <= 8'h39) return 4'(c - 8'h30);
        if (c >= 8'h61) return 4'(c - 8'h57);
        return 4'(c - 8'h37);
    endfunction

    function automatic logic [7:0] up_hex(input logic [3:0] n);
        return (n < 4'd10) ? 8'(8'h30 + n) : 8'(8'h37 + n);
    endfunction

    // Whole-line semantics: valid W or R lines reply, empty lines are silent, anything else is an error.
    function automatic void model_line(input bq_t line, inout logic [7:0] led,
                                       output bq_t rep, output int errs);
        bit is_w;
        bit is_r;
        rep  = {};
        errs = 0;
        if (line.size() == 0) return;
        is_w = (line[0] == 8'h57) || (LC && line[0] == 8'h77);
        is_r = (line[0] == 8'h52) || (LC && line[0] == 8'h72);
        if (is_w && line.size() == 3 && is_hex(line[1]) && is_hex(line[2])) begin
            led = {hex_val(line[1]), hex_val(line[2])};
            rep.push_back(8'h4B);
            rep.push_back(8'h0A);
        end else if (is_r && line.size() == 1) begin
            rep.push_back(up_hex(led[7:4]));
            rep.push_back(up_hex(led[3:0]));
            rep.push_back(8'h0A);
        end else begin
            rep.push_back(8'h21);
            rep.push_back(8'h0A);
            errs = 1;
        end
    endfunction

    function automatic bq_t s2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    function automatic logic [31:0] pack(input bq_t q);
        logic [31:0] v = 32'h0;
        foreach (q[i]) v = {v[23:0], q[i]};
        return v;
    endfunction

    function automatic logic [7:0] rnd_hex_char();
        int n = $urandom_range(0, 15);
        if (n < 10) return 8'(8'h30 + n);
        return 8'(((($urandom_range(0, 2) == 0) ? 8'h61 : 8'h41)) + n - 10);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_byte_i  = b;
        bus.rx_valid_i = 1'b1;
        @(negedge clk);
        bus.rx_valid_i = 1'b0;
    endtask

    task automatic send_body(input bq_t line, input int max_gap);
        foreach (line[i]) begin
            send_byte(line[i]);
            idle($urandom_range(0, max_gap));
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        bus.rx_valid_i = 1'b0;
        bus.rx_byte_i  = 8'h00;
        idle(4);
        total++; if (bus.led_o !== LED_RST) begin bad++; $display("FAIL reset_led: got %h want %h", bus.led_o, LED_RST); end
        total++; if (bus.tx_start_o !== 1'b0) begin bad++; $display("FAIL reset_tx_start: got %b want 0", bus.tx_start_o); end
        total++; if (bus.tx_byte_o !== 8'h00) begin bad++; $display("FAIL reset_tx_byte: got %h want 00", bus.tx_byte_o); end
        total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus.err_o); end
        rst_n = 1'b1;
        idle(5);
        total++; if (txq.size() != 0) begin bad++; $display("FAIL reset_quiet: got %0d tx bytes want 0", txq.size()); end
    endtask

    task automatic test_write();
        int e0;
        txq.delete();
        e0 = err_cnt;
        send_body(s2q("W3C"), 2);
        total++; if (bus.led_o !== led_model) begin bad++; $display("FAIL write_led_before_cr: got %h want %h", bus.led_o, led_model); end
        send_byte(CR);
        total++; if (bus.led_o !== 8'h3C) begin bad++; $display("FAIL write_led_after_cr: got %h want 3c", bus.led_o); end
        led_model = 8'h3C;
        idle(60);
        total++; if (txq.size() != 2 || pack(txq) !== 32'h0000_4B0A) begin
            bad++; $display("FAIL write_reply: got n=%0d %h want n=2 00004b0a", txq.size(), pack(txq)); end
        total++; if (err_cnt - e0 != 0) begin bad++; $display("FAIL write_err: got %0d pulses want 0", err_cnt - e0); end
    endtask

    task automatic test_read();
        int e0;
        txq.delete();
        e0 = err_cnt;
        send_body(s2q("R"), 1);
        send_byte(LF);
        idle(60);
        total++; if (txq.size() != 3 || pack(txq) !== 32'h0033_430A) begin
            bad++; $display("FAIL read_reply: got n=%0d %h want n=3 0033430a", txq.size(), pack(txq)); end
        total++; if (bus.led_o !== 8'h3C) begin bad++; $display("FAIL read_led: got %h want 3c", bus.led_o); end
        total++; if (err_cnt - e0 != 0) begin bad++; $display("FAIL read_err: got %0d pulses want 0", err_cnt - e0); end
    endtask

    task automatic test_bad_hex();
        int e0;
        txq.delete();
        e0 = err_cnt;
        send_body(s2q("WZZ"), 2);
        send_byte(CR);
        idle(60);
        total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL badhex_err: got %0d pulses want 1", err_cnt - e0); end
        total++; if (txq.size() != 2 || pack(txq) !== 32'h0000_210A) begin
            bad++; $display("FAIL badhex_reply: got n=%0d %h want n=2 0000210a", txq.size(), pack(txq)); end
        total++; if (bus.led_o !== led_model) begin bad++; $display("FAIL badhex_led: got %h want %h", bus.led_o, led_model); end
    endtask

    task automatic test_timeout();
        int  e0;
        bq_t rep;
        int  errs;
        txq.delete();
        e0 = err_cnt;
        send_body(s2q("W3"), 0);
        // TO idle edges between the '3' and the 'R' (send_byte adds one more negedge before driving).
        idle(TO - 1);
        send_byte(8'h52);
        send_byte(CR);
        idle(60);
        model_line(s2q("R"), led_model, rep, errs);
        total++; if (txq.size() != rep.size() || pack(txq) !== pack(rep)) begin
            bad++; $display("FAIL timeout_reply: got n=%0d %h want n=%0d %h", txq.size(), pack(txq), rep.size(), pack(rep)); end
        total++; if (err_cnt - e0 != 0) begin bad++; $display("FAIL timeout_err: got %0d pulses want 0", err_cnt - e0); end
        // A slow but in-time command still completes.
        txq.delete();
        send_body(s2q("W5"), 0);
        idle(TO - 5);
        send_byte(8'h35);
        send_byte(CR);
        idle(60);
        model_line(s2q("W55"), led_model, rep, errs);
        total++; if (bus.led_o !== led_model) begin bad++; $display("FAIL slow_write_led: got %h want %h", bus.led_o, led_model); end
        total++; if (txq.size() != rep.size() || pack(txq) !== pack(rep)) begin
            bad++; $display("FAIL slow_write_reply: got n=%0d %h want n=%0d %h", txq.size(), pack(txq), rep.size(), pack(rep)); end
    endtask

    task automatic test_drop_during_reply();
        int  e0;
        int  waited;
        bq_t rep;
        int  errs;
        txq.delete();
        e0 = err_cnt;
        send_body(s2q("R"), 0);
        send_byte(CR);
        waited = 0;
        while (txq.size() == 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        total++; if (txq.size() == 0) begin bad++; $display("FAIL drop_first_byte: got 0 tx bytes within 100 cycles want >=1"); end
        send_byte(8'h58);
        idle(60);
        model_line(s2q("R"), led_model, rep, errs);
        total++; if (txq.size() != rep.size() || pack(txq) !== pack(rep)) begin
            bad++; $display("FAIL drop_reply: got n=%0d %h want n=%0d %h", txq.size(), pack(txq), rep.size(), pack(rep)); end
        total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL drop_err: got %0d pulses want 1", err_cnt - e0); end
        txq.delete();
        send_body(s2q("R"), 0);
        send_byte(CR);
        idle(60);
        total++; if (txq.size() != rep.size() || pack(txq) !== pack(rep)) begin
            bad++; $display("FAIL drop_next_read: got n=%0d %h want n=%0d %h", txq.size(), pack(txq), rep.size(), pack(rep)); end
        total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL drop_next_err: got %0d pulses want 1", err_cnt - e0); end
    endtask

    task automatic test_lowercase();
        int  e0;
        bq_t rep;
        int  errs;
        txq.delete();
        e0 = err_cnt;
        send_body(s2q("w5a"), 1);
        send_byte(LF);
        idle(60);
        model_line(s2q("w5a"), led_model, rep, errs);
        total++; if (bus.led_o !== led_model) begin bad++; $display("FAIL lower_led: got %h want %h", bus.led_o, led_model); end
        total++; if (txq.size() != rep.size() || pack(txq) !== pack(rep)) begin
            bad++; $display("FAIL lower_reply: got n=%0d %h want n=%0d %h", txq.size(), pack(txq), rep.size(), pack(rep)); end
        total++; if (err_cnt - e0 != errs) begin bad++; $display("FAIL lower_err: got %0d pulses want %0d", err_cnt - e0, errs); end
    endtask

    task automatic test_random();
        string pool = "WRwr09AFafZX! g";
        for (int n = 0; n < 30; n++) begin
            bq_t        line;
            bq_t        rep;
            int         errs;
            int         e0;
            int         kind;
            logic [7:0] term;
            kind = $urandom_range(0, 4);
            line = {};
            case (kind)
                0, 1: begin
                    line.push_back(($urandom_range(0, 3) == 0) ? 8'h77 : 8'h57);
                    line.push_back(rnd_hex_char());
                    line.push_back(rnd_hex_char());
                end
                2: line.push_back(($urandom_range(0, 3) == 0) ? 8'h72 : 8'h52);
                3: for (int k = 0; k < $urandom_range(1, 4); k++)
                       line.push_back(pool[$urandom_range(0, pool.len() - 1)]);
                default: ;
            endcase
            term = ($urandom_range(0, 1) == 0) ? CR : LF;
            txq.delete();
            e0 = err_cnt;
            send_body(line, 4);
            send_byte(term);
            idle(60);
            model_line(line, led_model, rep, errs);
            total++; if (txq.size() != rep.size() || pack(txq) !== pack(rep)) begin
                bad++; $display("FAIL rand_reply[%0d]: line=%h got n=%0d %h want n=%0d %h",
                                n, pack(line), txq.size(), pack(txq), rep.size(), pack(rep)); end
            total++; if (err_cnt - e0 != errs) begin
                bad++; $display("FAIL rand_err[%0d]: line=%h got %0d pulses want %0d", n, pack(line), err_cnt - e0, errs); end
            total++; if (bus.led_o !== led_model) begin
                bad++; $display("FAIL rand_led[%0d]: line=%h got %h want %h", n, pack(line), bus.led_o, led_model); end
        end
    endtask

    task automatic test_reset_mid_reply();
        int waited;
        int n_before;
        send_body(s2q("WA5"), 0);
        send_byte(CR);
        idle(60);
        txq.delete();
        send_body(s2q("R"), 0);
        send_byte(CR);
        waited = 0;
        while (txq.size() == 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        total++; if (txq.size() == 0) begin bad++; $display("FAIL rstmid_first_byte: got 0 tx bytes within 100 cycles want >=1"); end
        n_before = txq.size();
        rst_n = 1'b0;
        idle(1);
        total++; if (bus.tx_start_o !== 1'b0) begin bad++; $display("FAIL rstmid_tx_start: got %b want 0", bus.tx_start_o); end
        idle(4);
        rst_n = 1'b1;
        idle(60);
        total++; if (txq.size() != n_before) begin bad++; $display("FAIL rstmid_no_more_tx: got %0d bytes want %0d", txq.size(), n_before); end
        total++; if (bus.led_o !== LED_RST) begin bad++; $display("FAIL rstmid_led: got %h want %h", bus.led_o, LED_RST); end
        led_model = LED_RST;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_hex();
        test_timeout();
        test_drop_during_reply();
        test_lowercase();
        test_random();
        test_reset_mid_reply();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Downstream consumer of the UART receiver's byte strobe. Parses a line-oriented ASCII command protocol: write an 8-bit LED register, or read it back. Returns short ASCII replies through the UART transmitter handshake. Sits between the `uart` instance and the board LEDs in the top level.

## Interface
- `TIMEOUT_CYCLES`, 12_000_000: idle clocks allowed between bytes of a partial command before it is aborted (1 s at 12 MHz); minimum 2.
- `LED_RESET`, 8'h00: reset value of the LED register.
- `CLK_i` input 1: single clock; all logic on its rising edge.
- `RSTn_i` input 1: reset, synchronous, active-low.
- `rx_valid_i` input 1: one-cycle strobe, byte received.
- `rx_byte_i` input 8: received byte, valid with `rx_valid_i`.
- `tx_busy_i` input 1: transmitter currently sending.
- `tx_start_o` output 1: one-cycle request to send `tx_byte_o`.
- `tx_byte_o` output 8: byte to transmit, stable while `tx_start_o` is high.
- `led_o` output 8: LED register.
- `err_o` output 1: one-cycle pulse on a protocol error.

## Operation
- Terminator T = CR (0x0D) or LF (0x0A). Hex digits: '0'-'9', 'A'-'F'.
- Commands:
  - "W h h T": sets `led_o` = hh and replies "K\n".
  - "R T": replies hex hi, hex lo, "\n", using uppercase hex.
- States:
  - IDLE: 'W' goes to W_HI. 'R' goes to R_END. T is ignored (empty line). Any other byte goes to DISCARD.
  - W_HI / W_LO: a hex digit latches the nibble and advances (W_HI to W_LO, W_LO to W_END). A non-hex byte goes to DISCARD. T goes to ERR_REPLY.
  - W_END / R_END: T executes the command and goes to REPLY. Any other byte goes to DISCARD.
  - DISCARD: drops bytes until T, then goes to ERR_REPLY.
  - ERR_REPLY: pulses `err_o` for one cycle, loads reply "!\n", goes to REPLY.
  - REPLY: sends the reply buffer (max 3 bytes, 2-bit count) byte by byte, then returns to IDLE.
- A byte arriving in REPLY or ERR_REPLY is dropped and `err_o` pulses. State and reply are unaffected.
- Timeout counter:
  - Clears on every accepted byte.
  - Counts only in W_HI, W_LO, W_END, R_END and DISCARD.
  - On reaching `TIMEOUT_CYCLES - 1`, returns to IDLE silently: no reply, no `err_o`.
  - Counter width is `$clog2(TIMEOUT_CYCLES)`.
- `led_o` changes only on a completed W command.

## Timing
- Reset values: `led_o` = `LED_RESET`; `tx_start_o`, `err_o` = 0; `tx_byte_o` = 0; state IDLE; counters 0.
- Reset mid-command or mid-reply aborts immediately, with no further `tx_start_o`.
- `led_o` updates on the clock edge following the cycle in which the terminating `rx_valid_i` is sampled.
- `err_o` is high for one cycle:
  - in ERR_REPLY, the cycle after T; or
  - the cycle after a dropped byte.
- Reply handshake, per byte:
  - `tx_start_o` is high for exactly one cycle, when `tx_busy_i` is low in REPLY.
  - After the pulse, the block waits one cycle, then waits until `tx_busy_i` is low before the next pulse.
  - The first `tx_start_o` occurs at the earliest 1 cycle after entering REPLY.
- Simultaneous timeout expiry and `rx_valid_i`: the byte wins; the counter clears and the byte is processed.

## Configuration
- `UART_CMD_LOWERCASE_EN`:
  - Defined: 'w', 'r' and 'a'-'f' are also accepted, with meaning equal to their uppercase forms. Replies stay uppercase.
  - Undefined: lowercase bytes are protocol errors (IDLE or hex states go to DISCARD).

## Structure
- Package `uart_cmd_pkg` holds:
  - ASCII constants: CR, LF, 'W', 'R', 'K', '!', '\n'.
  - State enum.
  - Reply-length constant 3.
- Sub-module `hex_ascii_codec` (combinational):
  - ASCII to nibble plus valid flag, honouring the macro.
  - Nibble to uppercase ASCII.
- Decoder FSM, timeout counter and reply buffer live in `uart_cmd_decoder`.

## Test plan
- "W3C\r" with `tx_busy_i` modelled at 10 cycles per byte: `led_o` = 0x3C one cycle after CR; TX bytes 0x4B, 0x0A; no `err_o`.
- "W3C\r", then "R\n": TX bytes 0x33, 0x43, 0x0A; `led_o` stays 0x3C.
- "WZZ\r": one `err_o` pulse at CR; TX 0x21, 0x0A; `led_o` unchanged.
- "W3" then `TIMEOUT_CYCLES` idle clocks (bench `TIMEOUT_CYCLES` = 50), then "R\r": no reply for the aborted command; R reply reflects the old value.
- Send "R\r" and a byte 'X' during the reply: `err_o` pulses once; reply completes intact; the next "R\r" works.
- "w5a\n":
  - Macro defined: `led_o` = 0x5A, reply "K\n".
  - Macro undefined: reply "!\n", `led_o` unchanged.
- Additionally, `RSTn_i` low mid-reply: `tx_start_o` stops and `led_o` = `LED_RESET`.
